muldiv_iter: RTL and testbench

MULDIV_ITER -- requirements
Module: muldiv_iter

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_iter.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_iter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Covers the op encoding, the FSM states and wide two's-complement helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MADDU = 3'b100;
  localparam logic [2:0] OP_MADD  = 3'b101;
  localparam logic [2:0] OP_MSUBU = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  // The helpers work on a fixed wide vector; callers zero-extend and truncate.
  localparam int MAXW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [MAXW-1:0] neg_f(input logic [MAXW-1:0] x);
    return ~x + MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] abs_f(input logic [MAXW-1:0] x, input logic is_neg);
    return is_neg ? neg_f(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative MIPS-style multiply/divide unit: WIDTH radix-2 steps, then one fix-up cycle.
// Shift-add multiply and restoring divide on magnitudes; signs and accumulation applied in FIX.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             We,
  input  logic             HiLo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] wl_q, wl_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;

  logic             in_div, s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ok;
  logic             op_div;
  logic [2*WIDTH-1:0] prod, mac;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    d1_d      = d1_q;
    b_d       = b_q;
    wh_d      = wh_q;
    wl_d      = wl_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;

    in_div = ~Op[2] & Op[1];
    s1     = Op[0] & D1[WIDTH-1];
    s2     = Op[0] & D2[WIDTH-1];
    mag1   = WIDTH'(abs_f(MAXW'(D1), s1));
    mag2   = WIDTH'(abs_f(MAXW'(D2), s2));

    mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, b_q} : '0);
    div_shift = {wh_q, wl_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = ~div_diff[WIDTH];

    op_div = ~op_q[2] & op_q[1];
    prod   = neg_q ? (2*WIDTH)'(neg_f(MAXW'({wh_q, wl_q}))) : {wh_q, wl_q};
    mac    = op_q[1] ? ({acc_hi_q, acc_lo_q} - prod) : ({acc_hi_q, acc_lo_q} + prod);
    quo    = neg_q  ? WIDTH'(neg_f(MAXW'(wl_q))) : wl_q;
    rem    = rneg_q ? WIDTH'(neg_f(MAXW'(wh_q))) : wh_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = CALC;
          cnt_d     = '0;
          op_d      = Op;
          d1_d      = D1;
          // Divide iterates the dividend through LO; multiply shifts the multiplier out of LO.
          b_d       = in_div ? mag2 : mag1;
          wl_d      = in_div ? mag1 : mag2;
          wh_d      = '0;
          acc_hi_d  = hi_q;
          acc_lo_d  = lo_q;
          neg_d     = s1 ^ s2;
          rneg_d    = s1;
          dz_d      = in_div & (D2 == '0);
          divzero_d = 1'b0;
        end else if (We) begin
          if (HiLo) hi_d = D1;
          else      lo_d = D1;
        end
      end
      CALC: begin
        if (op_div) begin
          wh_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          wl_d = {wl_q[WIDTH-2:0], div_ok};
        end else begin
          wh_d = mul_sum[WIDTH:1];
          wl_d = {mul_sum[0], wl_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        divzero_d = dz_q;
        if (op_div) begin
          hi_d = dz_q ? d1_q : rem;
          lo_d = dz_q ? '1   : quo;
        end else if (op_q[2]) begin
          {hi_d, lo_d} = mac;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      d1_q      <= '0;
      b_q       <= '0;
      wh_q      <= '0;
      wl_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      d1_q      <= d1_d;
      b_q       <= b_d;
      wh_q      <= wh_d;
      wl_q      <= wl_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: cycle-level arithmetic model with a per-cycle compare,
// plus directed operations with hand-computed results.
module tb_muldiv_iter;

  localparam int WIDTH = 32;

  logic        Clk = 1'b0;
  logic        Rst, Start, We, HiLo;
  logic [2:0]  Op;
  logic [31:0] D1, D2;
  logic        Busy, Done, DivZero;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  muldiv_iter #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .D1(D1), .D2(D2),
    .We(We), .HiLo(HiLo), .Busy(Busy), .Done(Done), .DivZero(DivZero),
    .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: result computed with plain arithmetic at acceptance, committed WIDTH+1 edges later.
  logic [63:0] m_pend = '0;
  logic        m_pdz = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0, m_busy = 1'b0, m_done = 1'b0;

  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_pdz = 1'b0;
    p = op[0] ? 64'(sa * sb) : ({32'h0, a} * {32'h0, b});
    case (op)
      3'b010, 3'b011: begin
        if (b == 32'h0) begin
          m_pend = {a, 32'hFFFF_FFFF};
          m_pdz  = 1'b1;
        end else if (op[0]) begin
          q = sa / sb;
          r = sa % sb;
          m_pend = {r[31:0], q[31:0]};
        end else begin
          m_pend = {a % b, a / b};
        end
      end
      3'b100, 3'b101: m_pend = {m_hi, m_lo} + p;
      3'b110, 3'b111: m_pend = {m_hi, m_lo} - p;
      default:        m_pend = p;
    endcase
  endtask

  always @(posedge Clk) begin
    if (Rst) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          {m_hi, m_lo} = m_pend;
          m_dz   = m_pdz;
          m_done = 1'b1;
        end
      end else if (Start) begin
        model_op(Op, D1, D2);
        m_rem = WIDTH + 1;
        m_dz  = 1'b0;
      end else if (We) begin
        if (HiLo) m_hi = D1;
        else      m_lo = D1;
      end
      m_busy = (m_rem > 0);
    end
    #1;
    if (cmp_en) begin
      chk("cyc Busy", 64'(Busy), 64'(m_busy));
      chk("cyc Done", 64'(Done), 64'(m_done));
      chk("cyc DivZero", 64'(DivZero), 64'(m_dz));
      chk("cyc HI", 64'(HI), 64'(m_hi));
      chk("cyc LO", 64'(LO), 64'(m_lo));
    end
  end

  // Called at a negedge; launches one op and waits for its Done with a cycle budget.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input logic we_too);
    int bc;
    logic got;
    Start = 1'b1; Op = op; D1 = a; D2 = b; We = we_too; HiLo = 1'b1;
    @(negedge Clk);
    Start = 1'b0; We = 1'b0;
    bc = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        got = 1'b1;
        break;
      end
      if (Busy) bc++;
      @(negedge Clk);
    end
    chk({name, " done seen"}, 64'(got), 64'd1);
    chk({name, " busy cycles"}, 64'(bc), 64'(WIDTH + 1));
    chk({name, " HI"}, 64'(HI), 64'(ehi));
    chk({name, " LO"}, 64'(LO), 64'(elo));
    chk({name, " DivZero"}, 64'(DivZero), 64'(edz));
    @(negedge Clk);
    chk({name, " done single pulse"}, 64'(Done), 64'd0);
  endtask

  task automatic we_write(input logic hilo, input logic [31:0] val,
                          input logic [31:0] ehi, input logic [31:0] elo);
    We = 1'b1; HiLo = hilo; D1 = val;
    @(negedge Clk);
    We = 1'b0;
    chk("we HI", 64'(HI), 64'(ehi));
    chk("we LO", 64'(LO), 64'(elo));
  endtask

  initial begin
    logic got;
    Rst = 1'b1; Start = 1'b0; We = 1'b0; HiLo = 1'b0; Op = 3'b000; D1 = '0; D2 = '0;
    repeat (2) @(negedge Clk);
    chk("reset Busy", 64'(Busy), 64'd0);
    chk("reset Done", 64'(Done), 64'd0);
    chk("reset DivZero", 64'(DivZero), 64'd0);
    chk("reset HI", 64'(HI), 64'd0);
    chk("reset LO", 64'(LO), 64'd0);
    Rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge Clk);

    run_op("multu max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op("div -7/2", 3'b011, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div min/-1", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("divu 5/0", 3'b010, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("mult 3*4", 3'b001, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 1'b0);
    run_op("mult -3*5", 3'b001, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    run_op("divu max/10", 3'b010, 32'hFFFF_FFFF, 32'hA, 32'h5, 32'h1999_9999, 1'b0, 1'b0);
    run_op("div 7/-2", 3'b011, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div -5/0", 3'b011, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("start+we", 3'b001, 32'h2, 32'h2, 32'h0, 32'h4, 1'b0, 1'b1);

    we_write(1'b0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
    we_write(1'b1, 32'h0, 32'h0, 32'hFFFF_FFFF);
    run_op("madd 1*1", 3'b101, 32'h1, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0);
    run_op("msub 1*2", 3'b111, 32'h1, 32'h2, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("maddu max*2", 3'b100, 32'hFFFF_FFFF, 32'h2, 32'h2, 32'hFFFF_FFFC, 1'b0, 1'b0);
    run_op("msubu 1*3", 3'b110, 32'h1, 32'h3, 32'h2, 32'hFFFF_FFF9, 1'b0, 1'b0);

    // Start and We injected mid-operation must not disturb the running mult.
    Start = 1'b1; Op = 3'b001; D1 = 32'h2; D2 = 32'h3;
    @(negedge Clk);
    for (int c = 1; c <= WIDTH + 1; c++) begin
      Start = (c == 5);
      We    = (c == 10);
      HiLo  = 1'b0;
      D1    = (c == 5) ? 32'h9 : ((c == 10) ? 32'h7 : 32'h0);
      D2    = (c == 5) ? 32'h9 : 32'h0;
      @(negedge Clk);
    end
    Start = 1'b0; We = 1'b0;
    chk("busy-ignore done", 64'(Done), 64'd1);
    chk("busy-ignore LO", 64'(LO), 64'h6);
    chk("busy-ignore HI", 64'(HI), 64'h0);
    @(negedge Clk);

    // Reset aborts a divide in flight.
    Start = 1'b1; Op = 3'b011; D1 = 32'd100; D2 = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (11) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("abort Busy", 64'(Busy), 64'd0);
    chk("abort Done", 64'(Done), 64'd0);
    chk("abort DivZero", 64'(DivZero), 64'd0);
    chk("abort HI", 64'(HI), 64'd0);
    chk("abort LO", 64'(LO), 64'd0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done || Busy) got = 1'b1;
      @(negedge Clk);
    end
    chk("abort no late Done", 64'(got), 64'd0);

    run_op("mult 6*7 after abort", 3'b001, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 1'b0);

    cmp_en = 1'b0;
    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
